// File: rtl/squash_pkg.sv
// Shared types and constants for the automatic squash opponent:
// FSM state encoding, LFSR seed/taps, miss thresholds and reaction scaling.
package squash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRACK    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_SWING    = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Indexed by difficulty: 0 -> 64, 1 -> 32, 2 -> 16, 3 -> 0 (never misses on purpose)
    localparam logic [3:0][7:0] MISS_THRESH = {8'd0, 8'd16, 8'd32, 8'd64};

    function automatic logic [2:0] delay_mult(input logic [1:0] difficulty);
        return 3'd4 - {1'b0, difficulty};
    endfunction

endpackage

// File: rtl/squash_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the miss-chance source.
// Seeded on reset; the seed is non-zero so the state never reaches 0.
module squash_lfsr16
    import squash_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] state
);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_tap
            if (gi == 15) begin : g_msb
                assign lfsr_next[gi] = LFSR_TAPS[gi] & lfsr_reg[0];
            end else begin : g_bit
                assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_TAPS[gi] & lfsr_reg[0]);
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign state = lfsr_reg;

endmodule

// File: rtl/squash_cpu_player.sv
// CPU-controlled left player: watches the light bus for the ball reaching the
// left end and raises hit after a difficulty-scaled delay, with a random miss chance.
module squash_cpu_player
    import squash_pkg::*;
#(
    parameter int TARGET_IDX  = 15,
    parameter int REACT_UNIT  = 5_000_000,
    parameter int HOLD_CYCLES = 1_000_000,
    parameter int CNT_W       = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] light,
    input  logic        gamestate,
    input  logic [1:0]  difficulty,
    output logic        hit,
    output logic [7:0]  swings,
    output logic [3:0]  misses,
    output logic [2:0]  state_dbg
);

    localparam logic [15:0]      TARGET_MASK = 16'd1 << TARGET_IDX;
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REACT_LOAD  = CNT_W'(REACT_UNIT);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             hit_reg, hit_next;
    logic [7:0]       swings_reg, swings_next;
    logic [3:0]       misses_reg, misses_next;
    logic             prev_at_target_reg;

    logic             at_target;
    logic             arrival;
    logic             miss_draw;
    logic             inc_miss;
    logic             inc_swing;
    logic [CNT_W-1:0] react_delay;
    logic [15:0]      lfsr;
    logic             unused_lfsr_hi;

    squash_lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .state (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:8];

    // Anything other than exactly the target bit (idle bus, glitches) is "not there"
    assign at_target   = (light == TARGET_MASK);
    assign arrival     = at_target & ~prev_at_target_reg;
    assign miss_draw   = (lfsr[7:0] < MISS_THRESH[difficulty]);
    assign react_delay = REACT_LOAD * CNT_W'(delay_mult(difficulty));

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        inc_miss    = 1'b0;
        inc_swing   = 1'b0;

        if (!gamestate) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_TRACK;
                end
                ST_TRACK: begin
                    if (arrival) begin
                        if (miss_draw) begin
                            state_next = ST_COOLDOWN;
                            inc_miss   = 1'b1;
                        end else begin
                            state_next = ST_WAIT;
                            cnt_next   = react_delay;
                        end
                    end
                end
                ST_WAIT: begin
                    // Ball leaving before the reaction completes is a late miss
                    if (!at_target) begin
                        state_next = ST_COOLDOWN;
                        inc_miss   = 1'b1;
                    end else if (cnt_reg <= CNT_W'(1)) begin
                        state_next = ST_SWING;
                        cnt_next   = HOLD_LOAD;
                        inc_swing  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                ST_SWING: begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_next = ST_COOLDOWN;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                ST_COOLDOWN: begin
                    if (!at_target) begin
                        state_next = ST_TRACK;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        hit_next    = (state_next == ST_SWING);
        swings_next = (inc_swing && swings_reg != 8'hFF) ? swings_reg + 8'd1 : swings_reg;
        misses_next = (inc_miss && misses_reg != 4'hF) ? misses_reg + 4'd1 : misses_reg;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg          <= ST_IDLE;
            cnt_reg            <= '0;
            hit_reg            <= 1'b0;
            swings_reg         <= '0;
            misses_reg         <= '0;
            prev_at_target_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            cnt_reg            <= cnt_next;
            hit_reg            <= hit_next;
            swings_reg         <= swings_next;
            misses_reg         <= misses_next;
            prev_at_target_reg <= at_target;
        end
    end

    assign hit       = hit_reg;
    assign swings    = swings_reg;
    assign misses    = misses_reg;
    assign state_dbg = state_reg;

endmodule

// File: tb/tb_squash_cpu_player.sv
// Scoreboard bench for squash_cpu_player: expectations are queued as stimulus
// is applied and popped against sampled DUT outputs one clock later.
module tb_squash_cpu_player;
    import squash_pkg::*;

    localparam int RU = 4;
    localparam int HC = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] light = 16'h8000;
    logic        gamestate = 1'b1;
    logic [1:0]  difficulty = 2'd0;
    logic        hit;
    logic [7:0]  swings;
    logic [3:0]  misses;
    logic [2:0]  state_dbg;

    int checks   = 0;
    int failures = 0;
    int exp_swings = 0;
    int exp_misses = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] m_lfsr;

    squash_cpu_player #(
        .TARGET_IDX  (15),
        .REACT_UNIT  (RU),
        .HOLD_CYCLES (HC),
        .CNT_W       (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .light      (light),
        .gamestate  (gamestate),
        .difficulty (difficulty),
        .hit        (hit),
        .swings     (swings),
        .misses     (misses),
        .state_dbg  (state_dbg)
    );

    always #5 clock = ~clock;

    // Reference LFSR: x^16+x^14+x^13+x^11, right-shifting Galois, seed ACE1
    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq(e.tag, got, e.val);
        end
    endtask

    task automatic exp4(input string tag, input logic h, input int s, input int m, input state_t st);
        push_exp({tag, "_hit"}, 32'(h));
        push_exp({tag, "_swings"}, 32'(s));
        push_exp({tag, "_misses"}, 32'(m));
        push_exp({tag, "_state"}, 32'(st));
    endtask

    task automatic obs4();
        pop_check(32'(hit));
        pop_check(32'(swings));
        pop_check(32'(misses));
        pop_check(32'(state_dbg));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int thr(input int d);
        case (d)
            0: return 64;
            1: return 32;
            2: return 16;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic go_track();
        light = 16'h4000;
        tick();
    endtask

    // Idle until the LFSR value that the next edge samples gives the wanted draw
    task automatic find_lfsr(input int d, input bit want_miss);
        int n = 0;
        while ((int'(m_lfsr[7:0]) < thr(d)) != want_miss && n < 500) begin
            tick();
            n++;
        end
        check_eq("lfsr_search", 32'(n < 500), 32'd1);
    endtask

    task automatic hit_cycle(input int d, input bit verbose);
        int dl;
        difficulty = 2'(d);
        go_track();
        find_lfsr(d, 1'b0);
        light = 16'h8000;
        dl = RU * (4 - d);
        for (int k = 1; k <= dl + HC + 1; k++)
            push_exp("hit_wave", 32'(k > dl && k <= dl + HC));
        for (int k = 1; k <= dl + HC + 1; k++) begin
            tick();
            pop_check(32'(hit));
        end
        exp_swings = sat(exp_swings + 1, 255);
        exp4("after_hit", 1'b0, exp_swings, exp_misses, ST_COOLDOWN);
        obs4();
        if (verbose)
            $display("TXN hit diff=%0d delay=%0d swings=%0d misses=%0d", d, dl, swings, misses);
    endtask

    task automatic miss_cycle(input bit verbose);
        difficulty = 2'd0;
        go_track();
        find_lfsr(0, 1'b1);
        light = 16'h8000;
        exp_misses = sat(exp_misses + 1, 15);
        exp4("dmiss", 1'b0, exp_swings, exp_misses, ST_COOLDOWN);
        tick();
        obs4();
        if (verbose)
            $display("TXN deliberate_miss misses=%0d", misses);
    endtask

    initial begin
        // Reset held with ball at target and game running
        repeat (3) tick();
        exp4("rst", 1'b0, 0, 0, ST_IDLE);
        obs4();
        reset = 1'b1;
        push_exp("rst_release_state", 32'(ST_TRACK));
        tick();
        pop_check(32'(state_dbg));
        $display("TXN reset_release state=%0d", state_dbg);

        // Normal hit at hardest difficulty, then no retrigger on the same ball
        hit_cycle(3, 1'b1);
        for (int k = 0; k < 5; k++) push_exp("no_rehit", 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            pop_check(32'(hit));
        end
        check_eq("no_rehit_swings", 32'(swings), 32'(exp_swings));

        // Late miss: ball leaves after 10 cycles of a 16-cycle reaction
        difficulty = 2'd0;
        go_track();
        find_lfsr(0, 1'b0);
        light = 16'h8000;
        for (int k = 0; k < 10; k++) push_exp("late_wait_hit", 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            pop_check(32'(hit));
        end
        light = 16'h4000;
        exp_misses = sat(exp_misses + 1, 15);
        exp4("late", 1'b0, exp_swings, exp_misses, ST_COOLDOWN);
        tick();
        obs4();
        push_exp("late_back_track", 32'(ST_TRACK));
        tick();
        pop_check(32'(state_dbg));
        $display("TXN late_miss misses=%0d", misses);

        // Deliberate miss and hits at the middle difficulties
        miss_cycle(1'b1);
        hit_cycle(1, 1'b1);
        hit_cycle(2, 1'b1);

        // gamestate falling on the arrival cycle wins; no miss counted
        difficulty = 2'd0;
        go_track();
        find_lfsr(0, 1'b1);
        light = 16'h8000;
        gamestate = 1'b0;
        exp4("gsfall", 1'b0, exp_swings, exp_misses, ST_IDLE);
        tick();
        obs4();
        gamestate = 1'b1;
        light = 16'h4000;
        tick();
        $display("TXN gamestate_fall_on_arrival misses=%0d", misses);

        // Abort mid-swing
        difficulty = 2'd3;
        go_track();
        light = 16'h8000;
        for (int k = 1; k <= 6; k++) push_exp("abort_wave", 32'(k > RU && k <= RU + HC));
        for (int k = 1; k <= 6; k++) begin
            tick();
            pop_check(32'(hit));
        end
        gamestate = 1'b0;
        exp_swings = sat(exp_swings + 1, 255);
        exp4("abort", 1'b0, exp_swings, exp_misses, ST_IDLE);
        tick();
        obs4();
        gamestate = 1'b1;
        light = 16'h4000;
        push_exp("abort_resume", 32'(ST_TRACK));
        tick();
        pop_check(32'(state_dbg));
        $display("TXN abort_mid_swing swings=%0d", swings);
        hit_cycle(3, 1'b1);

        // Two lit bits is not an arrival
        go_track();
        light = 16'h8001;
        for (int k = 0; k < 6; k++) begin
            push_exp("multi_hit", 32'd0);
            push_exp("multi_state", 32'(ST_TRACK));
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            pop_check(32'(hit));
            pop_check(32'(state_dbg));
        end
        $display("TXN non_one_hot state=%0d", state_dbg);

        // Saturation of both statistics
        for (int i = 0; i < 20; i++) miss_cycle(1'b0);
        check_eq("misses_sat", 32'(misses), 32'd15);
        $display("TXN miss_saturation misses=%0d", misses);
        for (int i = 0; i < 300; i++) hit_cycle(3, 1'b0);
        check_eq("swings_sat", 32'(swings), 32'd255);
        $display("TXN swing_saturation swings=%0d", swings);

        // Asynchronous reset in the middle of WAIT, checked before any edge
        difficulty = 2'd3;
        go_track();
        light = 16'h8000;
        push_exp("areset_pre_state", 32'(ST_WAIT));
        tick();
        tick();
        pop_check(32'(state_dbg));
        #2 reset = 1'b0;
        #1;
        exp4("areset", 1'b0, 0, 0, ST_IDLE);
        obs4();
        $display("TXN async_reset state=%0d swings=%0d misses=%0d", state_dbg, swings, misses);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
